// File: rtl/board_update_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : board_update_sequencer_if
// Brief  : Shared board-RAM port: display read request in, RAM write/address out.
// Rev    : 1.0
// ============================================================================
interface board_update_sequencer_if;
  logic       rd_req;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic       rd_grant;
  logic       mem_we;
  logic [3:0] mem_x;
  logic [3:0] mem_y;
  logic [1:0] mem_wdata;

  modport master (
    input  rd_req, rd_x, rd_y,
    output rd_grant, mem_we, mem_x, mem_y, mem_wdata
  );

  modport slave (
    output rd_req, rd_x, rd_y,
    input  rd_grant, mem_we, mem_x, mem_y, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/board_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module : board_update_sequencer
// Brief  : Per-tick board rebuild (clear, snake, food) on a RAM port shared
//          with display reads. Optional macro HEAD_CODE_EN writes the head as 11.
// Rev    : 1.0
// ============================================================================
module board_update_sequencer #(
  parameter int MAX_LEN = 225,
  parameter int LEN_W   = 8,
  parameter int CELLS   = 256
) (
  input  wire                      clk,
  input  wire                      reset,
  input  wire                      start,
  input  wire [MAX_LEN*8-1:0]      snake_in,
  input  wire [LEN_W-1:0]          snake_len,
  input  wire [3:0]                food_x,
  input  wire [3:0]                food_y,
  board_update_sequencer_if.master mem,
  output logic                     busy,
  output logic                     done
);

  localparam int             c_CNT_W   = 8;
  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [c_CNT_W-1:0] c_LAST_CELL = c_CNT_W'(CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SNAKE = 3'd2,
    S_FOOD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state, w_next_state;
  logic [c_CNT_W-1:0]   r_cnt, w_next_cnt;
  logic [MAX_LEN*8-1:0] r_snake;
  logic [LEN_W-1:0]     r_len;
  logic [3:0]           r_food_x, r_food_y;

  logic [7:0] w_seg;
  logic [1:0] w_snake_code;
  logic       w_we, w_grant;
  logic [3:0] w_x, w_y;
  logic [1:0] w_wdata;

  assign w_seg = r_snake[{r_cnt, 3'b000} +: 8];

`ifdef HEAD_CODE_EN
  assign w_snake_code = (r_cnt == '0) ? 2'b11 : 2'b10;
`else
  assign w_snake_code = 2'b10;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Game inputs are captured once so later changes cannot disturb a running update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snake  <= '0;
      r_len    <= '0;
      r_food_x <= '0;
      r_food_y <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_snake  <= snake_in;
      r_len    <= (snake_len > c_MAX_LEN) ? c_MAX_LEN : snake_len;
      r_food_x <= food_x;
      r_food_y <= food_y;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_we         = 1'b0;
    w_grant      = 1'b0;
    w_x          = 4'd0;
    w_y          = 4'd0;
    w_wdata      = 2'b00;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_CLEAR;
          w_next_cnt   = '0;
        end
      end
      S_CLEAR: begin
        w_we = 1'b1;
        w_x  = r_cnt[3:0];
        w_y  = r_cnt[7:4];
        if (!mem.rd_req) begin
          if (r_cnt == c_LAST_CELL) begin
            w_next_state = (r_len == '0) ? S_FOOD : S_SNAKE;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + c_CNT_W'(1);
          end
        end
      end
      S_SNAKE: begin
        w_we    = 1'b1;
        w_x     = w_seg[3:0];
        w_y     = w_seg[7:4];
        w_wdata = w_snake_code;
        if (!mem.rd_req) begin
          if (LEN_W'(r_cnt) == r_len - LEN_W'(1)) begin
            w_next_state = S_FOOD;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + c_CNT_W'(1);
          end
        end
      end
      S_FOOD: begin
        w_we    = 1'b1;
        w_x     = r_food_x;
        w_y     = r_food_y;
        w_wdata = 2'b01;
        if (!mem.rd_req) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Reset quiets the port immediately, but a display read still gets through.
    if (reset) begin
      w_we    = 1'b0;
      w_wdata = 2'b00;
      w_x     = 4'd0;
      w_y     = 4'd0;
      busy    = 1'b0;
      done    = 1'b0;
    end

    if (mem.rd_req) begin
      w_grant = 1'b1;
      w_we    = 1'b0;
      w_wdata = 2'b00;
      w_x     = mem.rd_x;
      w_y     = mem.rd_y;
    end
  end

  assign mem.rd_grant  = w_grant;
  assign mem.mem_we    = w_we;
  assign mem.mem_x     = w_x;
  assign mem.mem_y     = w_y;
  assign mem.mem_wdata = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_board_update_sequencer.sv
`default_nettype none
// Bench for board_update_sequencer: directed and randomized updates compared
// against an ordered expected-write list and final board image built from the rules.
module tb_board_update_sequencer;
  localparam int MAX_LEN = 225;
  localparam int LEN_W   = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [MAX_LEN*8-1:0] snake_in;
  logic [LEN_W-1:0]     snake_len;
  logic [3:0]           food_x, food_y;
  logic                 busy, done;

  board_update_sequencer_if bus ();

  board_update_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CELLS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .snake_in(snake_in),
    .snake_len(snake_len), .food_x(food_x), .food_y(food_y),
    .mem(bus.slave), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] seg [MAX_LEN];
  logic [9:0] exp_q [$];
  logic [1:0] board [256];
  logic [1:0] exp_board [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_segs();
    for (int i = 0; i < MAX_LEN; i++) seg[i] = 8'($urandom);
  endtask

  // Expected writes in order: every cell cleared, each segment, then food.
  task automatic build_expected(input int len, input int fx, input int fy, output int eff_len);
    logic [1:0] code;
    logic [7:0] cidx;
    eff_len = (len > MAX_LEN) ? MAX_LEN : len;
    exp_q.delete();
    for (int c = 0; c < 256; c++) begin
      cidx = 8'(c);
      exp_q.push_back({cidx[3:0], cidx[7:4], 2'b00});
      exp_board[c] = 2'b00;
      board[c] = 2'b11;
    end
    for (int i = 0; i < eff_len; i++) begin
      code = 2'b10;
`ifdef HEAD_CODE_EN
      if (i == 0) code = 2'b11;
`endif
      exp_q.push_back({seg[i][3:0], seg[i][7:4], code});
      exp_board[seg[i]] = code;
    end
    exp_q.push_back({4'(fx), 4'(fy), 2'b01});
    exp_board[{4'(fy), 4'(fx)}] = 2'b01;
  endtask

  task automatic launch(input int len, input int fx, input int fy);
    @(negedge clk);
    for (int i = 0; i < MAX_LEN; i++) snake_in[8*i +: 8] = seg[i];
    snake_len = LEN_W'(len);
    food_x    = 4'(fx);
    food_y    = 4'(fy);
    start     = 1'b1;
  endtask

  task automatic run_update(input int len, input int fx, input int fy,
                            input int stall_at, input int stall_len,
                            input bit rnd_stall, input int poke_at);
    int  eff_len, stalls, err0, bad;
    bit  rq, finished;
    logic [9:0] e;
    build_expected(len, fx, fy, eff_len);
    launch(len, fx, fy);
    stalls = 0;
    finished = 1'b0;
    err0 = n_err;
    for (int k = 1; k <= 1200 && !finished && n_err < err0 + 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      rq = (k >= stall_at && k < stall_at + stall_len) ||
           (rnd_stall && $urandom_range(0, 7) == 0);
      bus.rd_req = rq;
      bus.rd_x   = 4'($urandom);
      bus.rd_y   = 4'($urandom);
      if (k == poke_at) begin
        start = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) snake_in[8*i +: 8] = 8'($urandom);
        snake_len = LEN_W'($urandom);
        food_x = 4'($urandom);
        food_y = 4'($urandom);
      end
      #1;
      check("busy_during_update", 32'(busy), 32'd1);
      if (rq) begin
        check("rd_grant", 32'(bus.rd_grant), 32'd1);
        check("we_during_read", 32'(bus.mem_we), 32'd0);
        check("read_addr", {24'd0, bus.mem_x, bus.mem_y}, {24'd0, bus.rd_x, bus.rd_y});
      end else begin
        check("no_grant", 32'(bus.rd_grant), 32'd0);
      end
      if (exp_q.size() == 0) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_cycle", 32'(k), 32'(258 + eff_len + stalls));
        if (!rq) check("we_at_done", 32'(bus.mem_we), 32'd0);
        finished = 1'b1;
      end else begin
        check("no_early_done", 32'(done), 32'd0);
        if (rq) begin
          stalls++;
        end else begin
          e = exp_q.pop_front();
          check("write_we", 32'(bus.mem_we), 32'd1);
          check("write_xy_code", {22'd0, bus.mem_x, bus.mem_y, bus.mem_wdata}, {22'd0, e});
          board[{bus.mem_y, bus.mem_x}] = bus.mem_wdata;
        end
      end
    end
    check("update_finished", 32'(finished), 32'd1);
    bus.rd_req = 1'b0;
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      check("idle_after_done", {30'd0, busy, done}, 32'd0);
    end
    bad = 0;
    for (int c = 0; c < 256; c++) if (board[c] !== exp_board[c]) bad++;
    check("board_image", 32'(bad), 32'd0);
  endtask

  task automatic abort_update(input int len, input int abort_k);
    int eff_len, noisy;
    rand_segs();
    build_expected(len, 3, 4, eff_len);
    launch(len, 3, 4);
    for (int k = 1; k < abort_k; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    bus.rd_req = 1'b0;
    #1;
    check("abort_we_in_reset", 32'(bus.mem_we), 32'd0);
    check("abort_addr_in_reset", {24'd0, bus.mem_x, bus.mem_y}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(bus.mem_we), 32'd0);
    noisy = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      #1;
      if (done || busy || bus.mem_we) noisy++;
    end
    check("abort_no_done", 32'(noisy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    snake_in = '0;
    snake_len = '0;
    food_x = '0;
    food_y = '0;
    bus.rd_req = 1'b1;
    bus.rd_x = 4'h7;
    bus.rd_y = 4'hA;
    #1;
    check("reset_read_grant", 32'(bus.rd_grant), 32'd1);
    check("reset_read_addr", {24'd0, bus.mem_x, bus.mem_y}, 32'h7A);
    repeat (2) @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    check("reset_addr", {24'd0, bus.mem_x, bus.mem_y}, 32'd0);
    check("reset_outputs", {28'd0, bus.mem_we, bus.mem_wdata, busy}, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Scenario 1: three segments, food at (9,2)
    rand_segs();
    seg[0] = 8'h55; seg[1] = 8'h54; seg[2] = 8'h53;
    run_update(3, 9, 2, 0, 0, 1'b0, 0);

    // Scenario 2: empty snake
    rand_segs();
    run_update(0, 0, 0, 0, 0, 1'b0, 0);

    // Scenario 3: five-cycle display read landing on clear cell 40
    rand_segs();
    run_update(10, 15, 15, 41, 5, 1'b0, 0);

    // Scenario 4: over-long snake is clamped
    rand_segs();
    run_update(250, 7, 12, 0, 0, 1'b0, 0);

    // Scenario 5: start re-asserted and inputs changed mid-update
    rand_segs();
    run_update(40, 1, 14, 0, 0, 1'b0, 100);
    rand_segs();
    run_update(20, 6, 6, 0, 0, 1'b0, 265);

    // Randomized updates with random display contention
    for (int t = 0; t < 4; t++) begin
      rand_segs();
      run_update(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 0, 0, 1'b1, 0);
    end

    // Scenario 6: reset during SNAKE, then a clean update
    abort_update(20, 262);
    rand_segs();
    run_update(5, 4, 8, 0, 0, 1'b0, 0);

    // start coincident with reset is dropped
    @(negedge clk);
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    #1;
    check("start_with_reset", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/board_update_sequencer.md
Name: board_update_sequencer

Overview:
- Per game tick, rebuilds the 16x16 board RAM through its single port: clears every cell, writes each snake segment, then writes the food cell.
- Sits between game logic (snake vector, length, food position, tick) and the board RAM.
- Shares the same RAM port with the display read path; display reads always win, and the sequencer stalls while they are active.

Parameters:
- MAX_LEN, 225, maximum snake segments; snake_in is MAX_LEN*8 bits wide.
- LEN_W, 8, width of snake_len.
- CELLS, 256, board cells cleared per update (16x16, 4-bit x and y).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a board update (one-cycle pulse or level)
- snake_in  input  MAX_LEN*8  packed segments; segment i = bits [8i+7:8i], y = [8i+7:8i+4], x = [8i+3:8i]; segment 0 = head
- snake_len  input  LEN_W  number of valid segments
- food_x  input  4  food column
- food_y  input  4  food row
- rd_req  input  1  display read request
- rd_x  input  4  display read column
- rd_y  input  4  display read row
- rd_grant  output  1  RAM port given to display this cycle
- mem_we  output  1  RAM write enable
- mem_x  output  4  RAM column address
- mem_y  output  4  RAM row address
- mem_wdata  output  2  cell code: 00 empty, 01 food, 10 snake
- busy  output  1  update in progress
- done  output  1  one-cycle pulse at end of update

Behaviour:
- Reset values: state IDLE, counters 0, busy=0, done=0, mem_we=0, mem_wdata=00.
  - While reset is high and rd_req=0: mem_x=0, mem_y=0.
  - While reset is high and rd_req=1: mem_x/mem_y follow rd_x/rd_y and rd_grant=1.
- State machine: IDLE -> CLEAR -> SNAKE -> FOOD -> DONE -> IDLE.
- IDLE: start=1 at cycle N snapshots snake_in, clamped length, food_x and food_y, then moves to CLEAR. The bench sees this as a registered transition: busy=1 from cycle N+1.
- CLEAR: counter c = 0..CELLS-1.
  - Write mem_x=c[3:0], mem_y=c[7:4], wdata=00.
  - After c=CELLS-1: go to SNAKE, or to FOOD if the length is 0.
- SNAKE: index i = 0..L-1.
  - Write the segment i coordinates with wdata=10.
  - After i=L-1: go to FOOD.
- FOOD: write (food_x, food_y) with wdata=01, then go to DONE. Food is written last, so it overrides any overlapping snake cell.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- Length clamp: L = min(snake_len, MAX_LEN).
- Timing with no stalls:
  - writes occupy cycles N+1..N+257+L;
  - done pulses at cycle N+258+L;
  - total 258+L cycles busy.
- Arbitration (combinational):
  - rd_req=1: rd_grant=1, mem_we=0, mem_x/mem_y=rd_x/rd_y.
  - In CLEAR/SNAKE/FOOD, the state and counters hold; the pending write is issued in the first cycle rd_req=0.
  - In IDLE/DONE, rd_req has no effect on the state machine.
- No write is ever lost or duplicated; every stalled cycle adds exactly one cycle to the update.
- start while busy: ignored, not queued.
- start and reset in the same cycle: reset wins.
- reset mid-update: abort immediately to IDLE; no done pulse; the board is left partially written.
- Input changes after start: snake_in, snake_len, food_x and food_y have no effect on an update already in progress.

Optional Feature:
- Macro: HEAD_CODE_EN.
- Defined: segment 0 is written with wdata=11 (head); segments 1..L-1 use 10.
- Undefined: all segments use 10, and code 11 is never produced.

Test Plan:
1. Reset then start with snake_len=3, segments 0x55,0x54,0x53, food (9,2):
   - 256 clear writes, then writes (5,5),(4,5),(3,5) with 10, then (9,2) with 01;
   - done at cycle N+261.
2. snake_len=0, food (0,0): 256 clears, then a single food write; done at N+258; no 10 writes.
3. Hold rd_req=1 for 5 cycles during CLEAR at c=40:
   - rd_grant=1 and mem_we=0 for those cycles, with mem_x/mem_y tracking rd_x/rd_y;
   - clear resumes at c=40; done is delayed by exactly 5 cycles.
4. snake_len=250 with MAX_LEN=225: exactly 225 snake writes.
5. Re-assert start mid-update, and change snake_in mid-update: the update is unaffected.
6. Assert reset during SNAKE:
   - next cycle busy=0 and mem_we=0, with no done pulse;
   - a fresh start then completes normally.
   - With HEAD_CODE_EN defined, scenario 1 writes segment 0 (5,5) with 11.
